// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate block self-test: state encoding,
// vector count and the golden truth table of the AND/OR/NOT gate block.
package gate_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int NUM_VEC = 4;
  localparam int VEC_W   = 2;
  localparam int Y_W     = 3;
  localparam int ERR_W   = 3;

  // y[2]=AND, y[1]=OR, y[0]=NOT a
  function automatic logic [Y_W-1:0] expected(input logic a, input logic b);
    return {a & b, a | b, ~a};
  endfunction

endpackage

// File: rtl/gate_expect.sv
// Combinational golden model: maps operand pair {a,b} to the expected gate output.
module gate_expect
  import gate_test_pkg::*;
(
  input  logic           a,
  input  logic           b,
  output logic [Y_W-1:0] y_exp
);

  assign y_exp = expected(a, b);

endmodule

// File: rtl/gate_selftest_ctrl.sv
// Self-test sequencer: walks {a,b} through 00..11, holds each for DWELL cycles,
// checks the gate output against the golden model and records the result.
module gate_selftest_ctrl
  import gate_test_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [Y_W-1:0]   y,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [VEC_W-1:0] fail_vec
);

  localparam logic [7:0]       CNT_LAST = 8'(DWELL - 1);
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VEC - 1);

  state_e             state, state_n;
  logic [VEC_W-1:0]   vec, vec_n;
  logic [7:0]         cnt, cnt_n;
  logic [ERR_W-1:0]   err_n;
  logic [VEC_W-1:0]   fail_n;
  logic               seen, seen_n;
  logic [VEC_W-1:0]   ab_n;
  logic [Y_W-1:0]     y_exp;
  logic               mism;

  gate_expect u_expect (
    .a     (vec[1]),
    .b     (vec[0]),
    .y_exp (y_exp)
  );

  assign mism = (y != y_exp);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      vec      <= '0;
      cnt      <= '0;
      err_cnt  <= '0;
      fail_vec <= '0;
      seen     <= 1'b0;
      a        <= 1'b0;
      b        <= 1'b0;
    end else begin
      state    <= state_n;
      vec      <= vec_n;
      cnt      <= cnt_n;
      err_cnt  <= err_n;
      fail_vec <= fail_n;
      seen     <= seen_n;
      {a, b}   <= ab_n;
    end
  end

  always_comb begin
    state_n = state;
    vec_n   = vec;
    cnt_n   = cnt;
    err_n   = err_cnt;
    fail_n  = fail_vec;
    seen_n  = seen;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_n = ST_APPLY;
          vec_n   = '0;
          cnt_n   = '0;
          err_n   = '0;
          fail_n  = '0;
          seen_n  = 1'b0;
        end
      end
      ST_APPLY: begin
        cnt_n = cnt + 8'd1;
        if (cnt == CNT_LAST) state_n = ST_CHECK;
      end
      ST_CHECK: begin
        if (mism) begin
          err_n = err_cnt + ERR_W'(1);
          // only the first failing vector of a run is reported
          if (!seen) begin
            fail_n = vec;
            seen_n = 1'b1;
          end
        end
        if (vec == VEC_LAST) begin
          state_n = ST_DONE;
        end else begin
          vec_n   = vec + VEC_W'(1);
          cnt_n   = '0;
          state_n = ST_APPLY;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // operands follow the vector under test one edge ahead so they are
    // already stable in the first APPLY cycle of each vector
    ab_n = (state_n == ST_APPLY || state_n == ST_CHECK) ? vec_n : '0;
  end

  assign busy = (state == ST_APPLY) || (state == ST_CHECK);
  assign done = (state == ST_DONE);
  assign pass = done && (err_cnt == '0);

endmodule
